// File: rtl/fas_peak_analyzer.sv
// Serial FFT-bin peak finder: squares each bin's magnitude, keeps the running
// maximum per frame and reports index, magnitude and threshold detect at frame end.
module fas_peak_analyzer #(
    parameter int NBINS   = 16,
    parameter int DW      = 16,
    parameter int IDXW    = $clog2(NBINS),
    parameter bit SKIP_DC = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bin_valid,
    output logic              bin_ready,
    input  logic [DW-1:0]     bin_re,
    input  logic [DW-1:0]     bin_im,
    input  logic              bin_last,
    input  logic [2*DW:0]     thresh,
    output logic              done,
    output logic [IDXW-1:0]   freq,
    output logic [2*DW:0]     peak_mag,
    output logic              peak_found,
    output logic              frame_err
);
    localparam int MW = 2*DW+1;
    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBINS-1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [IDXW-1:0]     r_idx;
    logic [MW-1:0]       r_thresh;
    logic                r_s1_valid;
    logic [MW-1:0]       r_s1_mag;
    logic [IDXW-1:0]     r_s1_idx;
    logic                r_err_pend;
    logic [MW-1:0]       r_best_mag;
    logic [IDXW-1:0]     r_best_idx;
    logic                r_done;
    logic [IDXW-1:0]     r_freq;
    logic [MW-1:0]       r_peak_mag;
    logic                r_peak_found;
    logic                r_frame_err;

    logic                w_accept;
    logic                w_idx_end;
    logic                w_frame_end;
    logic                w_frame_err;
    logic                w_candidate;
    logic signed [2*DW-1:0] w_re_ext;
    logic signed [2*DW-1:0] w_im_ext;
    logic signed [2*DW-1:0] w_re_sq;
    logic signed [2*DW-1:0] w_im_sq;
    logic [MW-1:0]       w_mag;

    assign bin_ready   = (r_state == ST_ACCUM) && !rst;
    assign w_accept    = bin_valid && bin_ready;
    assign w_idx_end   = (r_idx == LAST_IDX);
    assign w_frame_end = bin_last || w_idx_end;
    assign w_frame_err = bin_last ^ w_idx_end;

    // Squares are non-negative and fit in 2*DW signed bits even for the most
    // negative input; the extra MSB of the sum absorbs the carry.
    assign w_re_ext = {{DW{bin_re[DW-1]}}, bin_re};
    assign w_im_ext = {{DW{bin_im[DW-1]}}, bin_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_mag    = {1'b0, w_re_sq} + {1'b0, w_im_sq};

    assign w_candidate = r_s1_valid
                      && !(SKIP_DC && (r_s1_idx == '0))
                      && (r_s1_mag > r_best_mag);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:  if (w_accept && w_frame_end) w_state_next = ST_DRAIN;
            ST_DRAIN:  w_state_next = ST_REPORT;
            ST_REPORT: w_state_next = ST_ACCUM;
            default:   w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACCUM;
            r_idx        <= '0;
            r_thresh     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_mag     <= '0;
            r_s1_idx     <= '0;
            r_err_pend   <= 1'b0;
            r_best_mag   <= '0;
            r_best_idx   <= '0;
            r_done       <= 1'b0;
            r_freq       <= '0;
            r_peak_mag   <= '0;
            r_peak_found <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            r_done     <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_accept) begin
                r_s1_mag <= w_mag;
                r_s1_idx <= r_idx;
                r_idx    <= w_frame_end ? '0 : r_idx + 1'b1;
                if (r_idx == '0) r_thresh <= thresh;
                if (w_frame_end) r_err_pend <= w_frame_err;
            end

            // REPORT never coincides with a valid S1 entry: bin_ready is low
            // on the two edges before it, so clearing best_* here is safe.
            if (r_state == ST_REPORT) begin
                r_done       <= 1'b1;
                r_frame_err  <= r_err_pend;
                r_freq       <= r_best_idx;
                r_peak_mag   <= r_best_mag;
                r_peak_found <= (r_best_mag > r_thresh);
                r_best_mag   <= '0;
                r_best_idx   <= '0;
            end else if (w_candidate) begin
                r_best_mag <= r_s1_mag;
                r_best_idx <= r_s1_idx;
            end
        end
    end

    assign done       = r_done;
    assign freq       = r_freq;
    assign peak_mag   = r_peak_mag;
    assign peak_found = r_peak_found;
    assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Scoreboard bench: three instances (16 bins, 16 bins with DC skip, 64 bins at
// DW=12) fed random and directed frames, each checked against a frame-level model.
module tb_fas_peak_analyzer;
    typedef struct {
        int     n;
        int     freq;
        longint mag;
        bit     found;
        bit     err;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instances A and B share their inputs; C is the wide-frame instance.
    logic        bv_ab = 1'b0, last_ab = 1'b0;
    logic [15:0] re_ab = '0, im_ab = '0;
    logic [32:0] th_ab = '0;
    logic        rdy_a, done_a, pf_a, fe_a, rdy_b, done_b, pf_b, fe_b;
    logic [3:0]  fq_a, fq_b;
    logic [32:0] pm_a, pm_b;

    logic        bv_c = 1'b0, last_c = 1'b0;
    logic [11:0] re_c = '0, im_c = '0;
    logic [24:0] th_c = '0;
    logic        rdy_c, done_c, pf_c, fe_c;
    logic [5:0]  fq_c;
    logic [24:0] pm_c;

    fas_peak_analyzer #(.NBINS(16), .DW(16), .SKIP_DC(1'b0)) u_a (
        .clk(clk), .rst(rst), .bin_valid(bv_ab), .bin_ready(rdy_a), .bin_re(re_ab),
        .bin_im(im_ab), .bin_last(last_ab), .thresh(th_ab), .done(done_a), .freq(fq_a),
        .peak_mag(pm_a), .peak_found(pf_a), .frame_err(fe_a));
    fas_peak_analyzer #(.NBINS(16), .DW(16), .SKIP_DC(1'b1)) u_b (
        .clk(clk), .rst(rst), .bin_valid(bv_ab), .bin_ready(rdy_b), .bin_re(re_ab),
        .bin_im(im_ab), .bin_last(last_ab), .thresh(th_ab), .done(done_b), .freq(fq_b),
        .peak_mag(pm_b), .peak_found(pf_b), .frame_err(fe_b));
    fas_peak_analyzer #(.NBINS(64), .DW(12), .SKIP_DC(1'b0)) u_c (
        .clk(clk), .rst(rst), .bin_valid(bv_c), .bin_ready(rdy_c), .bin_re(re_c),
        .bin_im(im_c), .bin_last(last_c), .thresh(th_c), .done(done_c), .freq(fq_c),
        .peak_mag(pm_c), .peak_found(pf_c), .frame_err(fe_c));

    exp_t qa[$], qb[$], qc[$];
    int   fre [256];
    int   fim [256];
    bit   flast [256];
    int   cyc = 0;
    int   frames_ab = 0, frames_c = 0, drv_to = 0;
    int   low_ab = 0, low_c = 0;
    int   n_checks = 0, n_fail = 0;
    bit   req_rst_in = 1'b0, req_post = 1'b0, req_end = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: bins up to the first bin_last (or the last index), strict max
    // with lowest index winning, optional DC exclusion.
    function automatic exp_t model(input int nb, input bit skip, input longint thr);
        exp_t   e;
        longint best, m;
        int     bi;
        e.n = nb;
        for (int i = 0; i < nb; i++) begin
            if (flast[i]) begin
                e.n = i + 1;
                break;
            end
        end
        e.err = (e.n == nb) ? !flast[nb-1] : 1'b1;
        best = 0;
        bi = 0;
        for (int i = 0; i < e.n; i++) begin
            if (skip && i == 0) continue;
            m = longint'(fre[i]) * fre[i] + longint'(fim[i]) * fim[i];
            if (m > best) begin
                best = m;
                bi = i;
            end
        end
        e.freq = bi;
        e.mag = best;
        e.found = (best > thr);
        e.cyc = 0;
        return e;
    endfunction

    function automatic int rnd_s(input int w);
        int v;
        v = int'($urandom_range(0, (1 << w) - 1));
        return v - (1 << (w - 1));
    endfunction

    task automatic fill(input int dw, input int mode);
        for (int i = 0; i < 256; i++) begin
            flast[i] = 1'b0;
            if (mode == 0) begin
                fre[i] = int'($urandom_range(0, 3)) - 1;
                fim[i] = int'($urandom_range(0, 3)) - 1;
            end else begin
                fre[i] = rnd_s(dw);
                fim[i] = rnd_s(dw);
            end
        end
    endtask

    task automatic drive_ab(input int re, input int im, input bit last);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_a) begin
            if (w >= 40) begin
                drv_to++;
                break;
            end
            bv_ab = 1'b1;
            re_ab = 16'($urandom);
            im_ab = 16'($urandom);
            last_ab = 1'($urandom);
            w++;
            @(negedge clk);
        end
        bv_ab = 1'b1;
        re_ab = 16'(re);
        im_ab = 16'(im);
        last_ab = last;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input int re, input int im, input bit last);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_c) begin
            if (w >= 40) begin
                drv_to++;
                break;
            end
            bv_c = 1'b1;
            re_c = 12'($urandom);
            im_c = 12'($urandom);
            last_c = 1'($urandom);
            w++;
            @(negedge clk);
        end
        bv_c = 1'b1;
        re_c = 12'(re);
        im_c = 12'(im);
        last_c = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ab(input int n);
        repeat (n) begin
            @(negedge clk);
            bv_ab = 1'b0;
            re_ab = 16'($urandom);
        end
    endtask

    task automatic run_ab(input longint thr, input bit gaps);
        exp_t ea, eb;
        ea = model(16, 1'b0, thr);
        eb = model(16, 1'b1, thr);
        for (int i = 0; i < ea.n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_ab(int'($urandom_range(1, 3)));
            if (i == 0) th_ab = 33'(thr);
            drive_ab(fre[i], fim[i], flast[i]);
            th_ab = {1'($urandom), 32'($urandom)};
        end
        bv_ab = 1'b0;
        ea.cyc = longint'(cyc) + 2;
        eb.cyc = ea.cyc;
        qa.push_back(ea);
        qb.push_back(eb);
        frames_ab++;
    endtask

    task automatic run_c(input longint thr, input bit gaps);
        exp_t e;
        e = model(64, 1'b0, thr);
        for (int i = 0; i < e.n; i++) begin
            if (gaps && $urandom_range(0, 4) == 0) begin
                @(negedge clk);
                bv_c = 1'b0;
            end
            if (i == 0) th_c = 25'(thr);
            drive_c(fre[i], fim[i], flast[i]);
            th_c = 25'($urandom);
        end
        bv_c = 1'b0;
        e.cyc = longint'(cyc) + 2;
        qc.push_back(e);
        frames_c++;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic res_check(input string tag, input exp_t e, input longint f, input longint m,
                             input longint pf, input longint fe);
        $display("%s result: bins=%0d freq=%0d mag=%0d found=%0d err=%0d at cycle %0d",
                 tag, e.n, f, m, pf, fe, cyc);
        chk({tag, "_freq"}, f, longint'(e.freq));
        chk({tag, "_peak_mag"}, m, e.mag);
        chk({tag, "_peak_found"}, pf, longint'(e.found));
        chk({tag, "_frame_err"}, fe, longint'(e.err));
        chk({tag, "_latency_cycle"}, longint'(cyc), e.cyc);
    endtask

    // Monitor: owns every comparison and the summary.
    always @(negedge clk) begin
        exp_t e;
        if (req_rst_in) begin
            chk("rst_ready_a", longint'(rdy_a), 0);
            chk("rst_ready_c", longint'(rdy_c), 0);
            chk("rst_done_a", longint'(done_a), 0);
        end
        if (req_post) begin
            chk("post_rst_ready_a", longint'(rdy_a), 1);
            chk("post_rst_ready_c", longint'(rdy_c), 1);
            chk("post_rst_freq_a", longint'(fq_a), 0);
            chk("post_rst_mag_a", longint'(pm_a), 0);
            chk("post_rst_found_a", longint'(pf_a), 0);
            chk("post_rst_err_a", longint'(fe_a), 0);
            chk("post_rst_freq_c", longint'(fq_c), 0);
            chk("post_rst_mag_c", longint'(pm_c), 0);
        end
        if (!rst && !rdy_a) low_ab++;
        if (!rst && !rdy_c) low_c++;
        if (!rst && done_a) begin
            chk("A_done_expected", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                res_check("A", e, longint'(fq_a), longint'(pm_a), longint'(pf_a), longint'(fe_a));
            end
        end
        if (!rst && done_b) begin
            chk("B_done_expected", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                res_check("B", e, longint'(fq_b), longint'(pm_b), longint'(pf_b), longint'(fe_b));
            end
        end
        if (!rst && done_c) begin
            chk("C_done_expected", longint'(qc.size() > 0), 1);
            if (qc.size() > 0) begin
                e = qc.pop_front();
                res_check("C", e, longint'(fq_c), longint'(pm_c), longint'(pf_c), longint'(fe_c));
            end
        end
        if (req_end) begin
            chk("A_pending_results", longint'(qa.size()), 0);
            chk("B_pending_results", longint'(qb.size()), 0);
            chk("C_pending_results", longint'(qc.size()), 0);
            chk("ready_low_cycles_ab", longint'(low_ab), longint'(2 * frames_ab));
            chk("ready_low_cycles_c", longint'(low_c), longint'(2 * frames_c));
            chk("ready_wait_timeouts", longint'(drv_to), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 req_rst_in = 1'b1;
        @(posedge clk);
        #1 req_rst_in = 1'b0;
        rst = 1'b0;
        req_post = 1'b1;
        @(posedge clk);
        #1 req_post = 1'b0;

        // Single dominant bin
        for (int i = 0; i < 256; i++) begin
            fre[i] = 10; fim[i] = 10; flast[i] = 1'b0;
        end
        fre[5] = 300; fim[5] = -400; flast[15] = 1'b1;
        run_ab(1000, 1'b0);
        idle_ab(6);

        // Reset at idx 8: partial frame dropped, outputs cleared
        fill(16, 1);
        for (int i = 0; i < 8; i++) drive_ab(fre[i], fim[i], 1'b0);
        bv_ab = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_post = 1'b1;
        @(posedge clk);
        #1 req_post = 1'b0;
        fill(16, 1);
        flast[15] = 1'b1;
        run_ab(longint'($urandom), 1'b1);

        // Tie at the most negative value
        for (int i = 0; i < 256; i++) begin
            fre[i] = 0; fim[i] = 0; flast[i] = 1'b0;
        end
        fre[3] = -32768; fre[9] = -32768; flast[15] = 1'b1;
        run_ab(0, 1'b1);

        // DC bin dominant: A reports bin 0, B skips it
        for (int i = 0; i < 256; i++) begin
            fre[i] = 0; fim[i] = 0; flast[i] = 1'b0;
        end
        fre[0] = 1000; fre[7] = 1; fim[7] = 1; flast[15] = 1'b1;
        run_ab(5, 1'b0);

        // All-zero frame
        for (int i = 0; i < 256; i++) begin
            fre[i] = 0; fim[i] = 0; flast[i] = 1'b0;
        end
        flast[15] = 1'b1;
        run_ab(0, 1'b0);

        // Short frame, then missing last
        fill(16, 1);
        flast[9] = 1'b1;
        run_ab(longint'($urandom), 1'b0);
        fill(16, 1);
        run_ab(longint'($urandom), 1'b1);

        // Random frames, back-to-back or gapped
        for (int k = 0; k < 24; k++) begin
            fill(16, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) flast[$urandom_range(0, 15)] = 1'b1;
            else if ($urandom_range(0, 4) != 0) flast[15] = 1'b1;
            run_ab({longint'($urandom_range(0, 1)), 32'($urandom)}, 1'($urandom));
        end
        idle_ab(6);

        // Wide instance: peak at the final index, then random frames
        fill(12, 0);
        fre[63] = -2048; fim[63] = -2048; flast[63] = 1'b1;
        run_c(8388607, 1'b1);
        for (int k = 0; k < 5; k++) begin
            fill(12, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) flast[$urandom_range(0, 63)] = 1'b1;
            else flast[63] = 1'b1;
            run_c(longint'($urandom_range(0, 4000000)), 1'($urandom));
        end

        repeat (10) @(posedge clk);
        #1 req_end = 1'b1;
    end
endmodule

// File: doc/fas_peak_analyzer.md
Name: fas_peak_analyzer

Overview:
Parametrised successor to the fixed 16-bin spectrum analysis stage. Accepts FFT bins serially over a valid/ready stream, computes each bin's squared magnitude in a two-stage pipeline and tracks the running maximum. At frame end it reports the peak bin index, the peak magnitude and a threshold-qualified detect flag. Sits between the FFT output serializer and the frequency-result consumer. Adds variable bin count, optional DC exclusion, framing-error detection and backpressure.

Parameters:
NBINS, 16, bins per frame (power of two, 4..256)
DW, 16, signed width of bin_re and bin_im (two's complement)
IDXW, $clog2(NBINS), bin index width
SKIP_DC, 0, 1 = bin 0 is never a peak candidate

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
bin_valid  in  1  bin_re/bin_im/bin_last valid
bin_ready  out  1  block can accept a bin
bin_re  in  DW  signed real part
bin_im  in  DW  signed imaginary part
bin_last  in  1  marks the final bin of a frame
thresh  in  2*DW+1  detect threshold, sampled on the first bin of each frame
done  out  1  one-cycle result pulse
freq  out  IDXW  index of the peak bin
peak_mag  out  2*DW+1  re^2+im^2 of the peak bin, unsigned
peak_found  out  1  peak_mag > thresh
frame_err  out  1  framing error, pulses together with done

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: bin_ready=0 during rst and 1 on the first cycle after rst deasserts. done=0, freq=0, peak_mag=0, peak_found=0, frame_err=0. Internal index, best magnitude, best index and pipeline valids are cleared.
- Accept rule: a bin is accepted on a rising edge when bin_valid && bin_ready. Inputs are ignored when bin_ready=0.
- Index counter: 0..NBINS-1. It increments per accepted bin and clears at frame end.
- Stage S1 (accept edge): register re*re + im*im, unsigned, 2*DW+1 bits, no truncation. The most negative input squared (e.g. -32768^2 for DW=16) must be exact. Also register the bin index and an end-of-frame flag.
- Stage S2 (next edge): if S1 is valid, and not (SKIP_DC and idx==0), and mag > best_mag, then best_mag=mag and best_idx=idx.
  - The comparison is strict, so on ties the lowest index wins.
  - best_mag and best_idx start each frame at 0/0, so an all-zero frame reports freq=0, peak_mag=0.
- Frame end is the first of these:
  - bin_last=1 on an accepted bin, or
  - an accepted bin with idx==NBINS-1.
- frame_err=1 if frame end occurs and the two conditions disagree:
  - bin_last=1 with idx<NBINS-1 (short frame), or
  - idx==NBINS-1 with bin_last=0 (missing last).
- Results are reported even on a framing error, using the bins received so far.
- State machine:
  - IDLE/ACCUM: bin_ready=1.
  - On acceptance of the frame-end bin at edge T, go to DRAIN1: bin_ready=0.
  - At edge T+1 (S2 compares the last bin), go to REPORT.
  - At edge T+2: register freq, peak_mag and peak_found (peak_mag > sampled thresh), set done=1 and frame_err as computed, then go to IDLE. best_* and the index clear.
  - done and frame_err are high for exactly the cycle between edges T+2 and T+3.
  - bin_ready is high again from edge T+2, so the first bin of the next frame may be accepted at edge T+3.
- Latency: result 2 cycles after the last-bin acceptance edge. Throughput: one bin per cycle, plus 2 bubble cycles per frame.
- freq, peak_mag and peak_found hold their values until the next done.
- thresh is sampled on acceptance of idx 0. Changes mid-frame have no effect.
- Reset mid-frame: the partial frame is discarded, with no done and no outputs changed from their reset values. Reset during REPORT suppresses done.
- Gaps: bin_valid may drop for any number of cycles mid-frame. No state is lost.

Test Plan:
- NBINS=16, DW=16: frame with bin 5 = (300,-400) and all others (10,10), thresh=1000 -> done 2 cycles after the last accept, freq=5, peak_mag=250000, peak_found=1, frame_err=0.
- Tie: bins 3 and 9 both (-32768,0), others 0 -> freq=3, peak_mag=1073741824 (exact, no overflow).
- SKIP_DC=1: bin 0 = (1000,0), bin 7 = (1,1), others 0 -> freq=7, peak_mag=2. SKIP_DC=0 with the same input -> freq=0, peak_mag=1000000.
- Short frame: bin_last on idx 9 -> done with frame_err=1 and freq taken from bins 0..9. Next frame starts at idx 0. Missing last: 16 bins with bin_last=0 -> frame_err=1.
- Backpressure/gaps: random bin_valid gaps, two back-to-back frames -> bin_ready low exactly 2 cycles per frame, no bin lost, both results correct. thresh changed mid-frame is ignored.
- Reset at idx 8 of a frame -> no done, outputs 0. A following clean frame reports correctly. Also run NBINS=64, DW=12 with the peak at idx 63.
